// File: rtl/sys_mode_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sys_mode_sequencer_pkg
//   Shared definitions for the mode sequencer: one-hot FSM state encodings,
//   status LED bit positions and a counter-width helper.
// ---------------------------------------------------------------------------
package sys_mode_sequencer_pkg;

    // One-hot controller states.
    typedef enum logic [5:0] {
        StDelay   = 6'b000001,
        StCfg     = 6'b000010,
        StCfgWait = 6'b000100,
        StRun     = 6'b001000,
        StWaitSof = 6'b010000,
        StFlush   = 6'b100000
    } state_e;

    // Bit positions inside o_status_leds = {cfg_err, flush, pending, cfg_ok}.
    localparam int unsigned LedCfgOk   = 0;
    localparam int unsigned LedPending = 1;
    localparam int unsigned LedFlush   = 2;
    localparam int unsigned LedCfgErr  = 3;

    // Width of a down-counter that must hold the value 'val' (never below 1 bit).
    function automatic int unsigned cnt_width(input int unsigned val);
        return (val < 1) ? 1 : $clog2(val + 1);
    endfunction

endpackage

// File: rtl/sys_mode_sequencer_input_filter.sv
// ---------------------------------------------------------------------------
// sys_mode_sequencer_input_filter
//   Synchronises one asynchronous input with two flops and debounces it: the
//   output takes the synchronised value only after DB_COUNT consecutive
//   samples that differ from the current output. Latency is 2 + DB_COUNT.
// Ports
//   i_clk   clock
//   i_rst   asynchronous active-high reset (output and counter clear)
//   i_raw   raw asynchronous input
//   o_filt  filtered, debounced level
// ---------------------------------------------------------------------------
module sys_mode_sequencer_input_filter
    import sys_mode_sequencer_pkg::*;
#(
    parameter int unsigned DB_COUNT = 2500000  // must be >= 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int unsigned CntW = cnt_width(DB_COUNT);
    localparam logic [CntW-1:0] Reload = CntW'((DB_COUNT > 0) ? DB_COUNT - 1 : 0);

    logic            r_meta;
    logic            r_sync;
    logic            r_filt;
    logic [CntW-1:0] r_cnt;
    logic            w_filt_d;
    logic [CntW-1:0] w_cnt_d;

    // Any sample equal to the output restarts the count, so only an
    // uninterrupted run of DB_COUNT differing samples flips the output.
    always_comb begin
        w_filt_d = r_filt;
        w_cnt_d  = Reload;
        if (r_sync != r_filt) begin
            if (r_cnt == '0) begin
                w_filt_d = r_sync;
            end else begin
                w_cnt_d = r_cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= Reload;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_filt <= w_filt_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/sys_mode_sequencer.sv
// ---------------------------------------------------------------------------
// sys_mode_sequencer
//   System controller in the i_sysclk domain. After reset it waits CFG_DELAY
//   cycles, pulses o_cfg_start and re-issues it every CFG_TIMEOUT cycles until
//   i_cfg_done. Once configured it tracks a debounced mode button and NUM_SW
//   debounced switches and applies any change only at the next i_sof,
//   followed by a FLUSH_CYCLES pipeline flush.
// Ports
//   i_sysclk       system clock
//   i_rst          asynchronous active-high reset
//   i_sof          start-of-frame pulse (i_sysclk domain)
//   i_cfg_done     camera configuration complete (level)
//   i_btn_mode     raw mode button (asynchronous)
//   i_sw           raw filter switches (asynchronous)
//   o_cfg_start    one-cycle configuration start pulse
//   o_mode         applied mode
//   o_sw           applied filter enables
//   o_pipe_flush   pipeline flush level
//   o_busy         high in every state except run
//   o_status_leds  {cfg_err, flush, pending, cfg_ok}
// ---------------------------------------------------------------------------
module sys_mode_sequencer
    import sys_mode_sequencer_pkg::*;
#(
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned NUM_SW       = 2,
    parameter int unsigned DB_COUNT     = 2500000,
    parameter int unsigned CFG_DELAY    = 125000,
    parameter int unsigned CFG_TIMEOUT  = 12500000,
    parameter int unsigned FLUSH_CYCLES = 16,
    localparam int unsigned MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              i_sysclk,
    input  logic              i_rst,
    input  logic              i_sof,
    input  logic              i_cfg_done,
    input  logic              i_btn_mode,
    input  logic [NUM_SW-1:0] i_sw,
    output logic              o_cfg_start,
    output logic [MODE_W-1:0] o_mode,
    output logic [NUM_SW-1:0] o_sw,
    output logic              o_pipe_flush,
    output logic              o_busy,
    output logic [3:0]        o_status_leds
);

    localparam int unsigned DelayW = cnt_width(CFG_DELAY);
    localparam int unsigned TmoW   = cnt_width(CFG_TIMEOUT);
    localparam int unsigned FlushW = cnt_width(FLUSH_CYCLES);
    localparam logic [MODE_W-1:0] LastMode = MODE_W'((NUM_MODES > 0) ? NUM_MODES - 1 : 0);

    // ------------------------------------------------------------------
    // Input filters: bit 0 is the button, bits NUM_SW:1 the switches.
    // ------------------------------------------------------------------
    logic [NUM_SW:0] w_raw;
    logic [NUM_SW:0] w_filt;
    logic            w_btn_filt;
    logic [NUM_SW-1:0] w_sw_filt;

    assign w_raw = {i_sw, i_btn_mode};

    for (genvar g = 0; g <= NUM_SW; g++) begin : g_filter
        sys_mode_sequencer_input_filter #(
            .DB_COUNT (DB_COUNT)
        ) u_filter (
            .i_clk  (i_sysclk),
            .i_rst  (i_rst),
            .i_raw  (w_raw[g]),
            .o_filt (w_filt[g])
        );
    end

    assign w_btn_filt = w_filt[0];
    assign w_sw_filt  = w_filt[NUM_SW:1];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_state_d;
    logic [DelayW-1:0] r_delay_cnt;
    logic [DelayW-1:0] w_delay_cnt_d;
    logic [TmoW-1:0]   r_tmo_cnt;
    logic [TmoW-1:0]   w_tmo_cnt_d;
    logic [FlushW-1:0] r_flush_cnt;
    logic [FlushW-1:0] w_flush_cnt_d;
    logic              r_btn_prev;
    logic              r_press_pend;
    logic              w_press_pend_d;
    logic [MODE_W-1:0] r_pend_mode;
    logic [MODE_W-1:0] w_pend_mode_d;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_d;
    logic [NUM_SW-1:0] r_sw;
    logic [NUM_SW-1:0] w_sw_d;
    logic              r_cfg_ok;
    logic              w_cfg_ok_d;
    logic              r_cfg_err;
    logic              w_cfg_err_d;

    logic w_btn_rise;
    logic w_pend;
    logic w_apply;
    logic w_cfg_timeout;

    assign w_btn_rise    = w_btn_filt & ~r_btn_prev & (NUM_MODES > 1);
    // A press is remembered separately so that presses wrapping pend_mode
    // back onto o_mode still request an SOF-aligned flush.
    assign w_pend        = r_press_pend | (r_pend_mode != r_mode) | (w_sw_filt != r_sw);
    assign w_apply       = (r_state == StWaitSof) & i_sof;
    assign w_cfg_timeout = (r_state == StCfgWait) & ~i_cfg_done & (r_tmo_cnt <= TmoW'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StDelay;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StDelay:   if (r_delay_cnt <= DelayW'(1)) w_state_d = StCfg;
            StCfg:     w_state_d = StCfgWait;
            StCfgWait: begin
                if (i_cfg_done) begin
                    w_state_d = StRun;
                end else if (w_cfg_timeout) begin
                    w_state_d = StCfg;
                end
            end
            StRun:     if (w_pend) w_state_d = StWaitSof;
            StWaitSof: if (i_sof) w_state_d = StFlush;
            StFlush:   if (r_flush_cnt <= FlushW'(1)) w_state_d = StRun;
            default:   w_state_d = StDelay;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_cfg_start  = (r_state == StCfg);
        o_pipe_flush = (r_state == StFlush);
        o_busy       = (r_state != StRun);
        o_status_leds             = '0;
        o_status_leds[LedCfgOk]   = r_cfg_ok;
        o_status_leds[LedPending] = w_pend;
        o_status_leds[LedFlush]   = (r_state == StFlush);
        o_status_leds[LedCfgErr]  = r_cfg_err;
    end

    assign o_mode = r_mode;
    assign o_sw   = r_sw;

    // ------------------------------------------------------------------
    // Counters, pending request and applied settings
    // ------------------------------------------------------------------
    always_comb begin
        w_delay_cnt_d = r_delay_cnt;
        if ((r_state == StDelay) && (r_delay_cnt > DelayW'(1))) begin
            w_delay_cnt_d = r_delay_cnt - DelayW'(1);
        end

        w_tmo_cnt_d = r_tmo_cnt;
        if (r_state == StCfg) begin
            w_tmo_cnt_d = TmoW'(CFG_TIMEOUT);
        end else if ((r_state == StCfgWait) && (r_tmo_cnt > TmoW'(1))) begin
            w_tmo_cnt_d = r_tmo_cnt - TmoW'(1);
        end

        w_flush_cnt_d = r_flush_cnt;
        if (w_apply) begin
            w_flush_cnt_d = FlushW'(FLUSH_CYCLES);
        end else if ((r_state == StFlush) && (r_flush_cnt > FlushW'(1))) begin
            w_flush_cnt_d = r_flush_cnt - FlushW'(1);
        end

        w_pend_mode_d = r_pend_mode;
        if (w_btn_rise) begin
            w_pend_mode_d = (r_pend_mode == LastMode) ? '0 : r_pend_mode + MODE_W'(1);
        end

        // A press landing in the apply cycle survives into the next frame.
        w_press_pend_d = r_press_pend;
        if (w_btn_rise) begin
            w_press_pend_d = 1'b1;
        end else if (w_apply) begin
            w_press_pend_d = 1'b0;
        end

        w_mode_d = r_mode;
        w_sw_d   = r_sw;
        if (w_apply) begin
            w_mode_d = r_pend_mode;
            w_sw_d   = w_sw_filt;
        end

        w_cfg_ok_d  = r_cfg_ok | ((r_state == StCfgWait) & i_cfg_done);
        w_cfg_err_d = r_cfg_err | w_cfg_timeout;
    end

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            r_delay_cnt  <= DelayW'(CFG_DELAY);
            r_tmo_cnt    <= TmoW'(CFG_TIMEOUT);
            r_flush_cnt  <= FlushW'(FLUSH_CYCLES);
            r_btn_prev   <= 1'b0;
            r_press_pend <= 1'b0;
            r_pend_mode  <= '0;
            r_mode       <= '0;
            r_sw         <= '0;
            r_cfg_ok     <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_delay_cnt  <= w_delay_cnt_d;
            r_tmo_cnt    <= w_tmo_cnt_d;
            r_flush_cnt  <= w_flush_cnt_d;
            r_btn_prev   <= w_btn_filt;
            r_press_pend <= w_press_pend_d;
            r_pend_mode  <= w_pend_mode_d;
            r_mode       <= w_mode_d;
            r_sw         <= w_sw_d;
            r_cfg_ok     <= w_cfg_ok_d;
            r_cfg_err    <= w_cfg_err_d;
        end
    end

endmodule

// File: tb/tb_sys_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sys_mode_sequencer
//   Self-checking bench for sys_mode_sequencer with short timing parameters.
//   Expected config pulse times and expected applied settings are queued when
//   stimulus is driven and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_sys_mode_sequencer;

    localparam int unsigned NUM_MODES    = 3;
    localparam int unsigned NUM_SW       = 2;
    localparam int unsigned DB_COUNT     = 4;
    localparam int unsigned CFG_DELAY    = 8;
    localparam int unsigned CFG_TIMEOUT  = 50;
    localparam int unsigned FLUSH_CYCLES = 3;
    localparam int unsigned MODE_W       = 2;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [NUM_SW-1:0] sw;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              i_sof;
    logic              i_cfg_done;
    logic              i_btn_mode;
    logic [NUM_SW-1:0] i_sw;
    logic              o_cfg_start;
    logic [MODE_W-1:0] o_mode;
    logic [NUM_SW-1:0] o_sw;
    logic              o_pipe_flush;
    logic              o_busy;
    logic [3:0]        o_status_leds;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   pulse_q[$];
    int   exp_mode = 0;

    sys_mode_sequencer #(
        .NUM_MODES    (NUM_MODES),
        .NUM_SW       (NUM_SW),
        .DB_COUNT     (DB_COUNT),
        .CFG_DELAY    (CFG_DELAY),
        .CFG_TIMEOUT  (CFG_TIMEOUT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_dut (
        .i_sysclk      (clk),
        .i_rst         (rst),
        .i_sof         (i_sof),
        .i_cfg_done    (i_cfg_done),
        .i_btn_mode    (i_btn_mode),
        .i_sw          (i_sw),
        .o_cfg_start   (o_cfg_start),
        .o_mode        (o_mode),
        .o_sw          (o_sw),
        .o_pipe_flush  (o_pipe_flush),
        .o_busy        (o_busy),
        .o_status_leds (o_status_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset released 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset();
        rst        = 1'b1;
        i_cfg_done = 1'b0;
        i_sof      = 1'b0;
        i_btn_mode = 1'b0;
        i_sw       = '0;
        exp_mode   = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Watch edges first..last for config pulses, popping expected edge numbers.
    task automatic watch_cfg(input int first, input int last, input int done_at);
        int want;
        for (int e = first; e <= last; e++) begin
            tick();
            if (o_cfg_start) begin
                n_checks++;
                if (pulse_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cfg_start_extra: pulse at edge %0d, none expected", e);
                end else begin
                    want = pulse_q.pop_front();
                    if (e !== want) begin
                        n_fail++;
                        $display("FAIL cfg_start_time: pulse at edge %0d, want %0d", e, want);
                    end
                end
            end
            if (e == done_at) i_cfg_done = 1'b1;
        end
    endtask

    task automatic bring_up();
        do_reset();
        i_cfg_done = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bring_up_busy: got %0b want 0", o_busy);
        end
    endtask

    task automatic press();
        i_btn_mode = 1'b1;
        repeat (6) tick();
        i_btn_mode = 1'b0;
        repeat (10) tick();
        exp_mode = (exp_mode + 1) % NUM_MODES;
    endtask

    // Pulse SOF, compare the applied settings against the scoreboard and
    // measure the flush length.
    task automatic apply_sof(input string name);
        exp_t e;
        int   len;
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
        n_checks++;
        if (o_pipe_flush !== 1'b1 || o_status_leds[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_flush_start: flush=%0b led=%0b want 1", name, o_pipe_flush,
                     o_status_leds[2]);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: no expected entry", name);
        end else begin
            e = sb_q.pop_front();
            if (o_mode !== e.mode || o_sw !== e.sw) begin
                n_fail++;
                $display("FAIL %s_applied: mode=%0d sw=%b want mode=%0d sw=%b", name, o_mode,
                         o_sw, e.mode, e.sw);
            end
        end
        len = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_pipe_flush) len++;
            else break;
        end
        n_checks++;
        if (len !== FLUSH_CYCLES) begin
            n_fail++;
            $display("FAIL %s_flush_len: got %0d want %0d", name, len, FLUSH_CYCLES);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after: got %0b want 0", name, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (o_mode !== 2'd0 || o_sw !== 2'b00 || o_pipe_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: mode=%0d sw=%b flush=%0b want 0", o_mode, o_sw,
                     o_pipe_flush);
        end
        n_checks++;
        if (o_cfg_start !== 1'b0 || o_status_leds !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: cfg_start=%0b leds=%b want 0", o_cfg_start,
                     o_status_leds);
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %0b want 1", o_busy);
        end
    endtask

    task automatic test_cfg_ok();
        do_reset();
        pulse_q.push_back(CFG_DELAY);
        watch_cfg(1, 20, 20);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_wait_busy: got %0b want 1", o_busy);
        end
        watch_cfg(21, 30, 0);
        n_checks++;
        if (o_busy !== 1'b0 || o_status_leds !== 4'b0001) begin
            n_fail++;
            $display("FAIL cfg_ok_state: busy=%0b leds=%b want busy=0 leds=0001", o_busy,
                     o_status_leds);
        end
        n_checks++;
        if (pulse_q.size() != 0) begin
            n_fail++;
            $display("FAIL cfg_ok_missing: %0d pulses not seen, want 0", pulse_q.size());
        end
    endtask

    task automatic test_cfg_timeout();
        do_reset();
        for (int k = 0; k < 3; k++) pulse_q.push_back(CFG_DELAY + k * (CFG_TIMEOUT + 1));
        watch_cfg(1, 58, 0);
        n_checks++;
        if (o_status_leds[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_early: got %0b want 0", o_status_leds[3]);
        end
        watch_cfg(59, 120, 0);
        n_checks++;
        if (o_status_leds[3] !== 1'b1 || o_status_leds[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_set: leds=%b want err=1 ok=0", o_status_leds);
        end
        n_checks++;
        if (pulse_q.size() != 0) begin
            n_fail++;
            $display("FAIL cfg_retry_missing: %0d pulses not seen, want 0", pulse_q.size());
        end
        i_cfg_done = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_status_leds !== 4'b1001) begin
            n_fail++;
            $display("FAIL cfg_err_sticky: busy=%0b leds=%b want busy=0 leds=1001", o_busy,
                     o_status_leds);
        end
    endtask

    task automatic test_mode_press();
        bring_up();
        press();
        sb_q.push_back('{mode: MODE_W'(exp_mode), sw: 2'b00});
        n_checks++;
        if (o_mode !== 2'd0 || o_status_leds[1] !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL press_before_sof: mode=%0d pend=%0b busy=%0b want 0,1,1", o_mode,
                     o_status_leds[1], o_busy);
        end
        apply_sof("press");
    endtask

    // Three presses from mode 1 wrap back to 1 but must still flush.
    task automatic test_coalesce();
        repeat (3) press();
        sb_q.push_back('{mode: MODE_W'(exp_mode), sw: 2'b00});
        n_checks++;
        if (o_status_leds[1] !== 1'b1 || o_mode !== 2'd1) begin
            n_fail++;
            $display("FAIL coalesce_pending: pend=%0b mode=%0d want 1,1", o_status_leds[1],
                     o_mode);
        end
        apply_sof("coalesce");
    endtask

    task automatic test_sw_glitch();
        i_sw = 2'b01;
        repeat (3) tick();
        i_sw = 2'b00;
        repeat (10) tick();
        n_checks++;
        if (o_status_leds[1] !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_pending: pend=%0b busy=%0b want 0,0", o_status_leds[1],
                     o_busy);
        end
        i_sw = 2'b01;
        repeat (10) tick();
        sb_q.push_back('{mode: MODE_W'(exp_mode), sw: 2'b01});
        n_checks++;
        if (o_sw !== 2'b00 || o_status_leds[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_before_sof: sw=%b pend=%0b want 00,1", o_sw, o_status_leds[1]);
        end
        apply_sof("sw");
    endtask

    task automatic test_sof_ignored();
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
        tick();
        n_checks++;
        if (o_pipe_flush !== 1'b0 || o_busy !== 1'b0 || o_mode !== 2'd1 || o_sw !== 2'b01) begin
            n_fail++;
            $display("FAIL sof_ignored: flush=%0b busy=%0b mode=%0d sw=%b want 0,0,1,01",
                     o_pipe_flush, o_busy, o_mode, o_sw);
        end
    endtask

    task automatic test_reset_mid_flush();
        i_sw = 2'b00;
        press();
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
        n_checks++;
        if (o_pipe_flush !== 1'b1 || o_mode !== MODE_W'(exp_mode) || o_sw !== 2'b00) begin
            n_fail++;
            $display("FAIL midflush_entry: flush=%0b mode=%0d sw=%b want 1,%0d,00",
                     o_pipe_flush, o_mode, o_sw, exp_mode);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_pipe_flush !== 1'b0 || o_mode !== 2'd0 || o_sw !== 2'b00 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midflush_async: flush=%0b mode=%0d sw=%b busy=%0b want 0,0,00,1",
                     o_pipe_flush, o_mode, o_sw, o_busy);
        end
        do_reset();
        pulse_q.push_back(CFG_DELAY);
        watch_cfg(1, 12, 0);
        n_checks++;
        if (pulse_q.size() != 0) begin
            n_fail++;
            $display("FAIL midflush_restart: %0d pulses not seen, want 0", pulse_q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_sof      = 1'b0;
        i_cfg_done = 1'b0;
        i_btn_mode = 1'b0;
        i_sw       = '0;
        test_reset();
        test_cfg_ok();
        test_cfg_timeout();
        test_mode_press();
        test_coalesce();
        test_sw_glitch();
        test_sof_ignored();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
